// File: rtl/keypad_entry_ctrl.sv
// ============================================================================
// Module   : keypad_entry_ctrl
// Purpose  : Debounced 10-key keypad front-end building a 4-digit BCD entry,
//            converted to binary on ENTER and handed off via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  key,
    input  logic        key_enter,
    input  logic        key_clear,
    input  logic        numero_ready,
    output logic [15:0] digits,
    output logic [2:0]  digit_count,
    output logic [13:0] numero,
    output logic        numero_valid,
    output logic        busy,
    output logic        error,
    output logic        timeout
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1) + 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) + 1 : 1;
    localparam logic [DW-1:0] c_deb_max = DW'(DEBOUNCE_CYCLES);
    localparam logic [TW-1:0] c_tmo_max = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESS   = 3'd1,
        S_RELEASE = 3'd2,
        S_CONVERT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [11:0]   sync1_q, sync2_q, prev_q;
    logic [DW-1:0] deb_q, deb_d;
    logic [15:0]   digits_q, digits_d;
    logic [2:0]    count_q, count_d;
    logic [13:0]   acc_q, acc_d;
    logic [1:0]    idx_q, idx_d;
    logic [13:0]   numero_q, numero_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;
    logic          timeout_q, timeout_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic [11:0]   w_v;
    logic [DW-1:0] w_run;
    logic          w_stable;
    logic          w_onehot;
    logic [3:0]    w_digit;
    logic [3:0]    w_cur_digit;
    logic [13:0]   w_acc_next;
    logic [TW-1:0] w_tmo_inc;
    logic          w_tmo_run;
    logic          w_accept;

    assign w_v         = sync2_q;
    assign w_stable    = (w_run >= c_deb_max);
    assign w_onehot    = (w_v != 12'd0) && ((w_v & (w_v - 12'd1)) == 12'd0);
    assign w_cur_digit = digits_q[{idx_q, 2'b00} +: 4];
    assign w_acc_next  = (acc_q * 14'd10) + {10'd0, w_cur_digit};
    assign w_tmo_inc   = tmo_q + TW'(1);
    assign w_tmo_run   = (TIMEOUT_CYCLES > 0) && (count_q != 3'd0) &&
                         ((state_q == S_IDLE) || (state_q == S_PRESS) ||
                          (state_q == S_RELEASE));

    // Run length of the current synchronized value, this cycle included.
    always_comb begin
        if (w_v != prev_q) begin
            w_run = DW'(1);
        end else if (deb_q >= c_deb_max) begin
            w_run = c_deb_max;
        end else begin
            w_run = deb_q + DW'(1);
        end
    end

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (w_v[i]) begin
                w_digit = 4'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        deb_d     = w_run;
        digits_d  = digits_q;
        count_d   = count_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        numero_d  = numero_q;
        valid_d   = valid_q;
        error_d   = 1'b0;
        timeout_d = 1'b0;
        tmo_d     = tmo_q;
        w_accept  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_v != 12'd0) begin
                    state_d = S_PRESS;
                end
            end
            S_PRESS: begin
                if (w_v == 12'd0) begin
                    state_d = S_IDLE;
                end else if (w_stable) begin
                    w_accept = 1'b1;
                    state_d  = S_RELEASE;
                    if (!w_onehot) begin
                        error_d = 1'b1;
                    end else if (w_v[11]) begin
                        digits_d = 16'd0;
                        count_d  = 3'd0;
                        tmo_d    = '0;
                    end else if (w_v[10]) begin
                        if (count_q != 3'd0) begin
                            acc_d   = 14'd0;
                            idx_d   = 2'(count_q - 3'd1);
                            state_d = S_CONVERT;
                        end
                    end else if (count_q < 3'd4) begin
                        digits_d = {digits_q[11:0], w_digit};
                        count_d  = count_q + 3'd1;
                        tmo_d    = '0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_RELEASE: begin
                if ((w_v == 12'd0) && w_stable) begin
                    state_d = S_IDLE;
                end
            end
            S_CONVERT: begin
                acc_d = w_acc_next;
                idx_d = idx_q - 2'd1;
                if (idx_q == 2'd0) begin
                    numero_d = w_acc_next;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (numero_ready) begin
                    valid_d  = 1'b0;
                    digits_d = 16'd0;
                    count_d  = 3'd0;
                    tmo_d    = '0;
                    state_d  = S_RELEASE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An accepted press in the same cycle suppresses the timeout.
        if (w_tmo_run && !w_accept) begin
            if (w_tmo_inc == c_tmo_max) begin
                digits_d  = 16'd0;
                count_d   = 3'd0;
                timeout_d = 1'b1;
                tmo_d     = '0;
            end else begin
                tmo_d = w_tmo_inc;
            end
        end

        if ((state_d == S_RELEASE) && (state_q != S_RELEASE)) begin
            deb_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sync1_q   <= 12'd0;
            sync2_q   <= 12'd0;
            prev_q    <= 12'd0;
            deb_q     <= '0;
            digits_q  <= 16'd0;
            count_q   <= 3'd0;
            acc_q     <= 14'd0;
            idx_q     <= 2'd0;
            numero_q  <= 14'd0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= {key_clear, key_enter, key};
            sync2_q   <= sync1_q;
            prev_q    <= w_v;
            deb_q     <= deb_d;
            digits_q  <= digits_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            numero_q  <= numero_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            tmo_q     <= tmo_d;
        end
    end

    assign digits       = digits_q;
    assign digit_count  = count_q;
    assign numero       = numero_q;
    assign numero_valid = valid_q;
    assign busy         = (state_q == S_CONVERT) || (state_q == S_DONE);
    assign error        = error_q;
    assign timeout      = timeout_q;

endmodule

`default_nettype wire

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Sequencing front-end for the 10-key numeric keypad. Synchronizes and debounces raw key lines and accepts one key per press/release cycle.
- Builds a 4-digit BCD entry buffer, calculator style. On ENTER, it converts the buffer to binary and hands the value over with a valid/ready handshake.
- Drives the per-digit 7-segment decoders (via `digits`) and the downstream consumer of the entered number.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive identical synchronized samples required to accept a press or a release (min 1).
- TIMEOUT_CYCLES, 1000, idle cycles after the last accepted digit before a partial entry is discarded; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- key  in  10  raw async digit keys, one bit per key; bit i = digit i, active-high.
- key_enter  in  1  raw async ENTER key, active-high.
- key_clear  in  1  raw async CLEAR key, active-high.
- numero_ready  in  1  consumer accepts `numero` when high together with `numero_valid`.
- digits  out  16  BCD buffer; [3:0] = most recently entered digit, [15:12] = oldest; unused digits are 0.
- digit_count  out  3  number of digits entered, 0..4.
- numero  out  14  binary value of the entry, 0..9999.
- numero_valid  out  1  `numero` is valid; held until handshake completes.
- busy  out  1  high in CONVERT and DONE.
- error  out  1  one-cycle pulse on a multi-key press or a digit into a full buffer.
- timeout  out  1  one-cycle pulse when an entry is discarded by timeout.

Behaviour:
- Reset (synchronous, active-high, wins over everything): all outputs 0, state IDLE, synchronizers/counters 0.
- Input path:
  - 2-flop synchronizer on the 12-bit vector v = {key_clear, key_enter, key}.
  - Debounce counter restarts whenever v differs from its previous sample.
- States: IDLE, PRESS, RELEASE, CONVERT, DONE.
- IDLE → PRESS when v ≠ 0.
- PRESS:
  - v returns to 0 before it is stable → IDLE, no action.
  - v stable and nonzero for DEBOUNCE_CYCLES cycles → the press is accepted in that cycle; its action commits on the next edge.
  - Exactly one bit of v must be set. Otherwise `error` pulses, there is no action, and the state goes → RELEASE.
- Accepted actions:
  - Digit d:
    - If digit_count < 4: digits ← {digits[11:0], d}, digit_count+1, timeout counter cleared. → RELEASE.
    - If digit_count == 4: buffer unchanged, `error` pulses. → RELEASE.
  - CLEAR: digits ← 0, digit_count ← 0. → RELEASE.
  - ENTER:
    - If digit_count == 0: ignored. → RELEASE.
    - Otherwise: accumulator ← 0, index ← digit_count−1, `busy` ← 1. → CONVERT.
- RELEASE → IDLE once v == 0 for DEBOUNCE_CYCLES consecutive cycles. A new press cannot be accepted before this.
- CONVERT:
  - Each cycle: acc ← acc*10 + digits[index*4 +: 4], index−1.
  - Runs exactly digit_count cycles, oldest digit first. 14-bit arithmetic; max 9999, cannot overflow.
  - After the last step: numero ← acc, numero_valid ← 1. → DONE.
  - Latency: numero_valid rises digit_count+1 edges after the ENTER-accepted cycle.
- DONE:
  - numero_valid and numero held stable until numero_ready is sampled high.
  - On that edge: numero_valid ← 0, busy ← 0, digits ← 0, digit_count ← 0. → RELEASE; the ENTER key may still be held.
  - numero_ready high in a cycle with numero_valid = 0 has no effect.
- Key activity in CONVERT and DONE is ignored (not buffered). Debounce is restarted on entry to RELEASE.
- Timeout:
  - Counter runs in IDLE, PRESS and RELEASE while digit_count > 0 and TIMEOUT_CYCLES > 0.
  - On reaching TIMEOUT_CYCLES: digits ← 0, digit_count ← 0, `timeout` pulses, counter ← 0.
  - A press accepted in the same cycle takes priority; the timeout is then suppressed.
- `numero` keeps its last value after the handshake; only reset zeroes it.

Test Plan:
- Press 1, 2, 3, 4 (each held 10 cycles, released 10 cycles, DEBOUNCE_CYCLES = 4) → digits = 0x1234, digit_count = 4. Then ENTER with numero_ready = 1 → numero = 1234, valid for 1 cycle, 5 edges after ENTER is accepted; then digits = 0, digit_count = 0.
- Key 7 bouncing (toggling every 2 cycles for 20 cycles), then stable for 4 cycles → exactly one digit 7 captured; a 3-cycle glitch alone → no change.
- Enter 9, 9, 9, 9, 5 → fifth press pulses `error`, digits stays 0x9999. ENTER with numero_ready = 0 for 10 cycles → numero_valid held at 9999 and busy = 1; keys pressed meanwhile are ignored; numero_ready = 1 → clears.
- Keys 3 and 5 pressed together → `error` pulse, no digit added. CLEAR after "42" → digits = 0, digit_count = 0. ENTER with an empty buffer → no numero_valid.
- TIMEOUT_CYCLES = 50: enter "8", then idle → `timeout` pulses and digits clears exactly 50 cycles after the digit was accepted. Assert reset during CONVERT → all outputs 0 on the next edge.
